// File: rtl/ntt_bf_scheduler.sv
// ntt_bf_scheduler: sequences the radix-4/radix-2 butterfly unit through a
// 512-point mixed-radix NTT/INTT. There are five stages per pass, 128 groups
// per stage, and one group is issued per cycle. A drain gap of BF_LAT cycles
// follows each stage, so the next stage never reads a group that has not
// been written back yet.
// Optional feature: define BF_SCHED_STALL_EN to add a `stall` input. A stall
// freezes issue during ISSUE, and the write-back delay line keeps shifting.
module ntt_bf_scheduler #(
  parameter int BF_LAT = 6,
  parameter int GRP_W  = 7,
  parameter int TW_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
`ifdef BF_SCHED_STALL_EN
  input  logic             stall,
`endif
  output logic             busy,
  output logic             done,
  output logic             sel,
  output logic             sel_ntt,
  output logic             rd_en,
  output logic [GRP_W-1:0] rd_idx,
  output logic [2:0]       stage,
  output logic [TW_W:0]    tw_addr,
  output logic             wr_en,
  output logic [GRP_W-1:0] wr_idx
);

  localparam int               CNT_W      = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [GRP_W-1:0] LAST_IDX   = {GRP_W{1'b1}};
  localparam logic [2:0]       LAST_STAGE = 3'd4;
  localparam int               R2_BASE    = 85;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic                         mode_q, mode_d;
  logic                         sel_q, sel_d;
  logic [2:0]                   stage_q, stage_d;
  logic [GRP_W-1:0]             rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]             drain_cnt_q, drain_cnt_d;
  logic [BF_LAT-1:0]            dl_en_q, dl_en_d;
  logic [BF_LAT-1:0][GRP_W-1:0] dl_idx_q, dl_idx_d;

  logic             issue_stall;
  logic             issue_en;
  logic [1:0]       r4_ord;
  logic [GRP_W-1:0] r4_shifted;
  logic [TW_W-1:0]  tw_idx;

`ifdef BF_SCHED_STALL_EN
  assign issue_stall = stall;
`else
  assign issue_stall = 1'b0;
`endif

  // Radix-4 stages are NTT 0..3 and INTT 1..4; the other stage is radix-2.
  function automatic logic radix4_sel(input logic m, input logic [2:0] s);
    return m ? (s != 3'd0) : (s != LAST_STAGE);
  endfunction

  // Radix-4 twiddle base for ordinal r: 0, 1, 5, 21 (sum of 4**j for j < r).
  function automatic int r4_base(input logic [1:0] r);
    return ((1 << (2 * int'(r))) - 1) / 3;
  endfunction

  // A group is read only while issuing and not stalled.
  assign issue_en = (state_q == S_ISSUE) && !issue_stall;

  // Next-state logic for the control FSM and the stage/index counters.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    stage_d     = stage_q;
    rd_idx_d    = rd_idx_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          mode_d   = mode;
          stage_d  = 3'd0;
          rd_idx_d = '0;
          sel_d    = radix4_sel(mode, 3'd0);
        end
      end
      S_ISSUE: begin
        if (!issue_stall) begin
          rd_idx_d = rd_idx_q + GRP_W'(1);
          if (rd_idx_q == LAST_IDX) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == CNT_W'(BF_LAT - 1)) begin
          if (stage_q != LAST_STAGE) begin
            // sel changes only here, so every in-flight group of a stage
            // sees a constant butterfly configuration.
            state_d  = S_ISSUE;
            stage_d  = stage_q + 3'd1;
            rd_idx_d = '0;
            sel_d    = radix4_sel(mode_q, stage_q + 3'd1);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The write-back delay line shifts every cycle, even while issue is stalled.
  always_comb begin
    dl_en_d     = dl_en_q;
    dl_idx_d    = dl_idx_q;
    dl_en_d[0]  = issue_en;
    dl_idx_d[0] = rd_idx_q;
    for (int i = 1; i < BF_LAT; i++) begin
      dl_en_d[i]  = dl_en_q[i-1];
      dl_idx_d[i] = dl_idx_q[i-1];
    end
  end

  // Twiddle index: radix-4 uses base(r) + (idx >> (7 - 2r)); radix-2 uses 85 + idx.
  always_comb begin
    r4_ord     = '0;
    r4_shifted = '0;
    tw_idx     = '0;
    if (sel_q) begin
      r4_ord     = mode_q ? 2'(stage_q - 3'd1) : stage_q[1:0];
      r4_shifted = rd_idx_q >> (GRP_W - 2 * int'(r4_ord));
      tw_idx     = TW_W'(r4_base(r4_ord)) + TW_W'(r4_shifted);
    end else begin
      tw_idx = TW_W'(R2_BASE) + TW_W'(rd_idx_q);
    end
  end

  // State registers; asynchronous reset aborts a transform and flushes writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      sel_q       <= 1'b0;
      stage_q     <= 3'd0;
      rd_idx_q    <= '0;
      drain_cnt_q <= '0;
      dl_en_q     <= '0;
      dl_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      stage_q     <= stage_d;
      rd_idx_q    <= rd_idx_d;
      drain_cnt_q <= drain_cnt_d;
      dl_en_q     <= dl_en_d;
      dl_idx_q    <= dl_idx_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    sel     = sel_q;
    sel_ntt = mode_q;
    rd_en   = issue_en;
    rd_idx  = rd_idx_q;
    stage   = stage_q;
    tw_addr = (state_q == S_ISSUE) ? {mode_q, tw_idx} : '0;
    wr_en   = dl_en_q[BF_LAT-1];
    wr_idx  = dl_idx_q[BF_LAT-1];
  end

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Testbench for ntt_bf_scheduler. Expected reads and write-backs for a whole
// transform are queued when start is driven. A monitor pops and compares them
// as the DUT issues them. Tests for the stall feature are built only when
// BF_SCHED_STALL_EN is defined.
module tb_ntt_bf_scheduler;
  localparam int BF_LAT = 6;
  localparam int GRP_W  = 7;
  localparam int TW_W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
`ifdef BF_SCHED_STALL_EN
  logic             stall = 1'b0;
`endif
  logic             busy, done, sel, sel_ntt, rd_en, wr_en;
  logic [GRP_W-1:0] rd_idx, wr_idx;
  logic [2:0]       stage;
  logic [TW_W:0]    tw_addr;

  ntt_bf_scheduler #(.BF_LAT(BF_LAT), .GRP_W(GRP_W), .TW_W(TW_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef BF_SCHED_STALL_EN
    .stall(stall),
`endif
    .busy(busy), .done(done), .sel(sel), .sel_ntt(sel_ntt),
    .rd_en(rd_en), .rd_idx(rd_idx), .stage(stage), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_idx(wr_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; int idx; int stg; int sel; int sntt; int tw; } rd_exp_t;
  typedef struct { int t; int idx; } wr_exp_t;
  rd_exp_t exp_rd_q[$];
  wr_exp_t exp_wr_q[$];

  int checks = 0, failures = 0;
  bit mon_en = 1'b0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, last_done_cyc = -1, exp_done_cyc = 0;

  // Scoreboard monitor: every issued read and every write-back is matched in order.
  always @(negedge clk) begin
    rd_exp_t er;
    wr_exp_t ew;
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (mon_en && rd_en === 1'b1) begin
      rd_cnt++;
      checks++;
      if (exp_rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected cyc=%0d rd_idx=%0d stage=%0d required=no read", cyc, rd_idx, stage);
      end else begin
        er = exp_rd_q.pop_front();
        if (cyc !== er.t || int'(rd_idx) !== er.idx || int'(stage) !== er.stg ||
            int'(sel) !== er.sel || int'(sel_ntt) !== er.sntt || int'(tw_addr) !== er.tw) begin
          failures++;
          $display("FAIL rd_issue got cyc=%0d idx=%0d stage=%0d sel=%0d sel_ntt=%0d tw=%0d required cyc=%0d idx=%0d stage=%0d sel=%0d sel_ntt=%0d tw=%0d",
                   cyc, rd_idx, stage, sel, sel_ntt, tw_addr, er.t, er.idx, er.stg, er.sel, er.sntt, er.tw);
        end
      end
    end
    if (mon_en && wr_en === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected cyc=%0d wr_idx=%0d required=no write", cyc, wr_idx);
      end else begin
        ew = exp_wr_q.pop_front();
        if (cyc !== ew.t || int'(wr_idx) !== ew.idx) begin
          failures++;
          $display("FAIL wr_back got cyc=%0d idx=%0d required cyc=%0d idx=%0d", cyc, wr_idx, ew.t, ew.idx);
        end
      end
    end
  end

  // Reference schedule: 5 stages of 128 reads, BF_LAT idle cycles after each stage.
  task automatic push_schedule(input bit m, input int c0, input int st_stage, input int st_idx, input int st_len);
    int t, ord, base;
    bit r4;
    rd_exp_t r;
    wr_exp_t w;
    t = c0 + 1;
    for (int s = 0; s < 5; s++) begin
      r4 = m ? (s != 0) : (s != 4);
      for (int i = 0; i < 128; i++) begin
        if (s == st_stage && i == st_idx) t += st_len;
        r.t = t; r.idx = i; r.stg = s; r.sel = int'(r4); r.sntt = int'(m);
        if (r4) begin
          ord  = m ? s - 1 : s;
          base = 0;
          for (int j = 0; j < ord; j++) base += (1 << (2 * j));
          r.tw = (m ? 256 : 0) + base + i / (128 / (1 << (2 * ord)));
        end else begin
          r.tw = (m ? 256 : 0) + 85 + i;
        end
        exp_rd_q.push_back(r);
        w.t = t + BF_LAT; w.idx = i;
        exp_wr_q.push_back(w);
        t++;
      end
      t += BF_LAT;
    end
    exp_done_cyc = t;
  endtask

  // Drive a one-cycle start pulse; c0 is the cycle in which start is sampled.
  task automatic start_tf(input bit m, input int st_stage, input int st_idx, input int st_len, output int c0);
    @(posedge clk); #1;
    c0 = cyc;
    push_schedule(m, c0, st_stage, st_idx, st_len);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic goto_cycle(input int target);
    for (int k = 0; k < 5000 && cyc < target; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 2000 && done_cnt == d0; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] allv;
    repeat (3) @(posedge clk);
    @(negedge clk);
    allv = {busy, done, sel, sel_ntt, rd_en, rd_idx, stage, tw_addr, wr_en, wr_idx};
    checks++;
    if (allv !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=00000000", allv);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b required=0", busy);
    end
    $display("tb: reset checked");
  endtask

  task automatic test_ntt();
    int c0, d0, rd0, wr0;
    d0 = done_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    start_tf(1'b0, -1, 0, 0, c0);
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || sel !== 1'b1 || stage !== 3'd0 || cyc !== c0 + 1) begin
      failures++;
      $display("FAIL ntt_first_rd got rd_en=%b sel=%b stage=%0d rel_cyc=%0d required rd_en=1 sel=1 stage=0 rel_cyc=1",
               rd_en, sel, stage, cyc - c0);
    end
    wait_done(d0);
    @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || last_done_cyc !== c0 + 671) begin
      failures++;
      $display("FAIL ntt_done got count=%0d rel_cyc=%0d required count=1 rel_cyc=671", done_cnt - d0, last_done_cyc - c0);
    end
    checks++;
    if (rd_cnt - rd0 !== 640 || wr_cnt - wr0 !== 640) begin
      failures++;
      $display("FAIL ntt_counts got rd=%0d wr=%0d required rd=640 wr=640", rd_cnt - rd0, wr_cnt - wr0);
    end
    checks++;
    if (busy !== 1'b0 || exp_rd_q.size() !== 0 || exp_wr_q.size() !== 0) begin
      failures++;
      $display("FAIL ntt_after got busy=%b rd_left=%0d wr_left=%0d required busy=0 rd_left=0 wr_left=0",
               busy, exp_rd_q.size(), exp_wr_q.size());
    end
    $display("tb: ntt transform, done at rel cycle %0d", last_done_cyc - c0);
  endtask

  task automatic test_intt();
    int c0, d0;
    d0 = done_cnt;
    start_tf(1'b1, -1, 0, 0, c0);
    @(negedge clk);
    checks++;
    if (sel !== 1'b0 || sel_ntt !== 1'b1 || tw_addr !== 9'd341) begin
      failures++;
      $display("FAIL intt_first got sel=%b sel_ntt=%b tw=%0d required sel=0 sel_ntt=1 tw=341", sel, sel_ntt, tw_addr);
    end
    wait_done(d0);
    @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || last_done_cyc !== exp_done_cyc || exp_wr_q.size() !== 0) begin
      failures++;
      $display("FAIL intt_done got count=%0d cyc=%0d wr_left=%0d required count=1 cyc=%0d wr_left=0",
               done_cnt - d0, last_done_cyc, exp_wr_q.size(), exp_done_cyc);
    end
    $display("tb: intt transform, done at rel cycle %0d", last_done_cyc - c0);
  endtask

  task automatic test_twiddle();
    int c0, d0;
    int tgt_s[5]  = '{2, 2, 2, 2, 3};
    int tgt_i[5]  = '{0, 7, 8, 127, 127};
    int tgt_tw[5] = '{5, 5, 6, 20, 84};
    bit hit;
    d0 = done_cnt;
    start_tf(1'b0, -1, 0, 0, c0);
    for (int p = 0; p < 5; p++) begin
      hit = 1'b0;
      for (int k = 0; k < 1000 && !hit; k++) begin
        @(negedge clk);
        if (rd_en === 1'b1 && int'(stage) == tgt_s[p] && int'(rd_idx) == tgt_i[p]) hit = 1'b1;
      end
      checks++;
      if (!hit || int'(tw_addr) !== tgt_tw[p]) begin
        failures++;
        $display("FAIL twiddle_s%0d_i%0d got hit=%0d tw=%0d required hit=1 tw=%0d", tgt_s[p], tgt_i[p], hit, tw_addr, tgt_tw[p]);
      end
    end
    wait_done(d0);
    $display("tb: twiddle-map transform, done at rel cycle %0d", last_done_cyc - c0);
  endtask

  task automatic test_start_ignored();
    int c0, d0, rd0;
    bit seen;
    d0 = done_cnt;
    start_tf(1'b0, -1, 0, 0, c0);
    goto_cycle(c0 + 50);
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    rd0 = rd_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || last_done_cyc !== c0 + 671) begin
      failures++;
      $display("FAIL start_ignored_done got count=%0d rel_cyc=%0d required count=1 rel_cyc=671", done_cnt - d0, last_done_cyc - c0);
    end
    checks++;
    if (busy !== 1'b0 || rd_cnt !== rd0) begin
      failures++;
      $display("FAIL start_ignored_restart got busy=%b reads=%0d required busy=0 reads=0", busy, rd_cnt - rd0);
    end
    $display("tb: start-ignored transform, done at rel cycle %0d", last_done_cyc - c0);
  endtask

  task automatic test_reset_mid();
    int c0, bad;
    logic [31:0] allv;
    start_tf(1'b0, -1, 0, 0, c0);
    goto_cycle(c0 + 300);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    allv = {busy, done, sel, sel_ntt, rd_en, rd_idx, stage, tw_addr, wr_en, wr_idx};
    checks++;
    if (allv !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h required=00000000", allv);
    end
    exp_rd_q.delete();
    exp_wr_q.delete();
    goto_cycle(c0 + 302);
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_mid_quiet got active_cycles=%0d required=0", bad);
    end
    mon_en = 1'b1;
    $display("tb: transform aborted by reset at rel cycle 300");
    test_ntt();
  endtask

`ifdef BF_SCHED_STALL_EN
  task automatic test_stall();
    int c0, d0, wr0, bad;
    d0 = done_cnt; wr0 = wr_cnt;
    start_tf(1'b0, 1, 10, 3, c0);
    goto_cycle(c0 + 145);
    stall = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rd_en !== 1'b0 || rd_idx !== 7'd10 || stage !== 3'd1) bad++;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stall_hold got bad_cycles=%0d required=0", bad);
    end
    wait_done(d0);
    @(negedge clk);
    checks++;
    if (last_done_cyc !== c0 + 674 || wr_cnt - wr0 !== 640 || exp_wr_q.size() !== 0) begin
      failures++;
      $display("FAIL stall_done got rel_cyc=%0d writes=%0d wr_left=%0d required rel_cyc=674 writes=640 wr_left=0",
               last_done_cyc - c0, wr_cnt - wr0, exp_wr_q.size());
    end
    $display("tb: stalled transform, done at rel cycle %0d", last_done_cyc - c0);
  endtask
`endif

  initial begin
    test_reset();
    test_ntt();
    test_intt();
    test_twiddle();
    test_start_ignored();
    test_reset_mid();
`ifdef BF_SCHED_STALL_EN
    test_stall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
